// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss timer datapath.
package timer_pkg;

    localparam int ONES_W = 4;
    localparam int TENS_W = 3;

    typedef logic [ONES_W-1:0] ones_t;
    typedef logic [TENS_W-1:0] tens_t;

    localparam tens_t MAX_TENS = 3'd5;
    localparam ones_t MAX_ONES = 4'd9;

    // Operating mode derived each cycle from the control FSM levels.
    typedef logic [2:0] mode_t;
    localparam mode_t RESET   = 3'd0;
    localparam mode_t COUNT   = 3'd1;
    localparam mode_t SET_SEC = 3'd2;
    localparam mode_t SET_MIN = 3'd3;
    localparam mode_t HOLD    = 3'd4;

    // Priority decode: clear first, then countdown, then the two set modes.
    function automatic mode_t decode_mode(input logic reset_timer, input logic enable_seg,
                                          input logic enable_min, input logic fwd);
        if (reset_timer)                              return RESET;
        if (enable_seg && enable_min && !fwd)         return COUNT;
        if (fwd && enable_seg && !enable_min)         return SET_SEC;
        if (fwd && !enable_seg && enable_min)         return SET_MIN;
        return HOLD;
    endfunction

endpackage

// File: rtl/timer_tick_scheduler_if.sv
// Control levels from the timer FSM and the BCD time / event outputs.
interface timer_tick_scheduler_if;
    import timer_pkg::*;

    logic  enableSeg;
    logic  enableMin;
    logic  forward;
    logic  resetTimer;
    ones_t secOnes;
    tens_t secTens;
    ones_t minOnes;
    tens_t minTens;
    logic  zero;
    logic  expired;

    // Control side (FSM / bench) drives levels and observes the time.
    modport master (
        output enableSeg, enableMin, forward, resetTimer,
        input  secOnes, secTens, minOnes, minTens, zero, expired
    );

    // Datapath side consumes levels and presents the time.
    modport slave (
        input  enableSeg, enableMin, forward, resetTimer,
        output secOnes, secTens, minOnes, minTens, zero, expired
    );
endinterface

// File: rtl/bcd60_counter.sv
// Two-digit BCD counter wrapping 00..59 in both directions.
module bcd60_counter
    import timer_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  clear,
    input  logic  inc,
    input  logic  dec,
    output ones_t ones,
    output tens_t tens,
    output logic  isZero,
    output logic  borrow
);

    ones_t ones_reg;
    tens_t tens_reg;

    assign ones   = ones_reg;
    assign tens   = tens_reg;
    assign isZero = (ones_reg == '0) && (tens_reg == '0);
    assign borrow = dec && isZero;

    // Digit update: clear beats inc beats dec; each wraps 59<->00.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ones_reg <= '0;
            tens_reg <= '0;
        end else if (clear) begin
            ones_reg <= '0;
            tens_reg <= '0;
        end else if (inc) begin
            if (ones_reg == MAX_ONES) begin
                ones_reg <= '0;
                tens_reg <= (tens_reg == MAX_TENS) ? '0 : tens_reg + 3'd1;
            end else begin
                ones_reg <= ones_reg + 4'd1;
            end
        end else if (dec) begin
            if (ones_reg == '0) begin
                ones_reg <= MAX_ONES;
                tens_reg <= (tens_reg == '0) ? MAX_TENS : tens_reg - 3'd1;
            end else begin
                ones_reg <= ones_reg - 4'd1;
            end
        end
    end

endmodule

// File: rtl/timer_tick_scheduler.sv
// Mode decode, tick prescaler and end-of-countdown event for the mm:ss timer.
module timer_tick_scheduler
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned SET_DIV  = 12_500_000
) (
    input  logic                   clk,
    input  logic                   reset,
    timer_tick_scheduler_if.slave  bus
);

    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
    localparam logic [31:0] SET_LAST  = 32'(SET_DIV - 1);

    mode_t       mode_now;
    mode_t       mode_reg;
    logic        mode_change;
    logic        counting;
    logic [31:0] presc_reg;
    logic [31:0] presc_next;
    logic [31:0] presc_eff;
    logic [31:0] div_last;
    logic        term;
    logic        tick_count;
    logic        tick_set;
    logic        expired_reg;
    logic        expired_next;

    logic        sec_zero;
    logic        min_zero;
    logic        sec_borrow;
    logic        sec_dec;
    logic        sec_inc;
    logic        min_inc;
    logic        clear_time;
    // Minutes never borrow: countdown stops at 00:00 before one could occur.
    logic        min_borrow_unused;

    assign mode_now    = decode_mode(bus.resetTimer, bus.enableSeg, bus.enableMin, bus.forward);
    assign mode_change = (mode_now != mode_reg);
    assign counting    = (mode_now == COUNT) || (mode_now == SET_SEC) || (mode_now == SET_MIN);
    assign div_last    = (mode_now == COUNT) ? TICK_LAST : SET_LAST;
    // A mode change discards any partial period, so the count restarts at 0 this cycle.
    assign presc_eff   = mode_change ? '0 : presc_reg;
    assign term        = counting && (presc_eff == div_last);
    assign tick_count  = term && (mode_now == COUNT);
    assign tick_set    = term && (mode_now != COUNT);

    assign clear_time  = (mode_now == RESET);
    assign sec_dec     = tick_count && !bus.zero;
    assign sec_inc     = tick_set && (mode_now == SET_SEC);
    assign min_inc     = tick_set && (mode_now == SET_MIN);

    assign bus.zero    = sec_zero && min_zero;
    assign bus.expired = expired_reg;

    // Prescaler next value: frozen in HOLD, cleared in RESET or on entry to a mode.
    always_comb begin
        presc_next = presc_reg;
        if (clear_time || mode_change) begin
            presc_next = '0;
        end
        if (counting) begin
            presc_next = term ? '0 : presc_eff + 32'd1;
        end
    end

    // The decrement from 00:01 is the one that lands on 00:00.
    always_comb begin
        expired_next = tick_count && min_zero &&
                       (bus.secTens == '0) && (bus.secOnes == 4'd1);
    end

    // Mode memory, prescaler and registered expiry pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_reg    <= HOLD;
            presc_reg   <= '0;
            expired_reg <= 1'b0;
        end else begin
            mode_reg    <= mode_now;
            presc_reg   <= presc_next;
            expired_reg <= expired_next;
        end
    end

    bcd60_counter u_sec (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear_time),
        .inc    (sec_inc),
        .dec    (sec_dec),
        .ones   (bus.secOnes),
        .tens   (bus.secTens),
        .isZero (sec_zero),
        .borrow (sec_borrow)
    );

    bcd60_counter u_min (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear_time),
        .inc    (min_inc),
        .dec    (sec_borrow),
        .ones   (bus.minOnes),
        .tens   (bus.minTens),
        .isZero (min_zero),
        .borrow (min_borrow_unused)
    );

endmodule

// File: tb/tb_timer_tick_scheduler.sv
// Directed scoreboard bench for the timer tick scheduler (TICK_DIV=4, SET_DIV=2).
module tb_timer_tick_scheduler;

    logic clk = 1'b0;
    logic reset;

    timer_tick_scheduler_if tif ();

    timer_tick_scheduler #(
        .TICK_DIV (4),
        .SET_DIV  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        bit    is_pulse_cnt;
        int    mm;
        int    ss;
        bit    z;
        bit    e;
        int    pulses;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;

    // Monitor: counts expiry pulses and compares every queued expectation at negedge.
    always @(negedge clk) begin
        exp_t x;
        int   so, st, mo, mt;
        if (!reset && tif.expired === 1'b1) pulses++;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            if (x.is_pulse_cnt) begin
                if (pulses != x.pulses) begin
                    errors++;
                    $display("FAIL %s: pulses got %0d want %0d", x.name, pulses, x.pulses);
                end else begin
                    $display("ok   %s: pulses %0d", x.name, pulses);
                end
            end else begin
                so = x.ss % 10; st = x.ss / 10; mo = x.mm % 10; mt = x.mm / 10;
                if (tif.minTens !== 3'(mt) || tif.minOnes !== 4'(mo) ||
                    tif.secTens !== 3'(st) || tif.secOnes !== 4'(so) ||
                    tif.zero !== x.z || tif.expired !== x.e) begin
                    errors++;
                    $display("FAIL %s: got %0d%0d:%0d%0d z=%b e=%b want %0d%0d:%0d%0d z=%b e=%b",
                             x.name, tif.minTens, tif.minOnes, tif.secTens, tif.secOnes,
                             tif.zero, tif.expired, mt, mo, st, so, x.z, x.e);
                end else begin
                    $display("ok   %s: %0d%0d:%0d%0d z=%b e=%b", x.name, tif.minTens,
                             tif.minOnes, tif.secTens, tif.secOnes, tif.zero, tif.expired);
                end
            end
        end
    end

    task automatic expect_time(input string name, input int mm, input int ss,
                               input bit z, input bit e);
        exp_t x;
        x.name = name; x.is_pulse_cnt = 1'b0; x.mm = mm; x.ss = ss;
        x.z = z; x.e = e; x.pulses = 0;
        sb.push_back(x);
    endtask

    task automatic expect_pulses(input string name, input int n);
        exp_t x;
        x.name = name; x.is_pulse_cnt = 1'b1; x.mm = 0; x.ss = 0;
        x.z = 1'b0; x.e = 1'b0; x.pulses = n;
        sb.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ctl(input bit rt, input bit es, input bit em, input bit fw);
        tif.resetTimer = rt;
        tif.enableSeg  = es;
        tif.enableMin  = em;
        tif.forward    = fw;
    endtask

    initial begin
        reset = 1'b1;
        ctl(0, 0, 0, 0);
        step(2);
        expect_time("reset_state", 0, 0, 1, 0);
        reset = 1'b0;
        step(3);
        expect_time("hold_after_reset", 0, 0, 1, 0);

        // SET_MIN: 61 ticks at 2 cycles each wraps minutes once to 01.
        ctl(0, 0, 1, 1);
        step(2);
        expect_time("setmin_first", 1, 0, 0, 0);
        step(120);
        expect_time("setmin_wrap", 1, 0, 0, 0);
        ctl(0, 0, 0, 0);
        step(4);
        expect_time("hold_frozen", 1, 0, 0, 0);

        // SET_SEC: preload 00:58, two more ticks wrap to 00:00 without carry.
        ctl(1, 0, 0, 0);
        step(1);
        expect_time("resettimer_clear", 0, 0, 1, 0);
        ctl(0, 1, 0, 1);
        step(116);
        expect_time("setsec_58", 0, 58, 0, 0);
        step(4);
        expect_time("setsec_wrap", 0, 0, 1, 0);

        // Countdown with borrow from 01:00 down to 00:00.
        ctl(0, 0, 1, 1);
        step(2);
        expect_time("preload_0100", 1, 0, 0, 0);
        ctl(0, 1, 1, 0);
        step(4);
        expect_time("count_borrow", 0, 59, 0, 0);
        step(235);
        expect_time("count_0001", 0, 1, 0, 0);
        step(1);
        expect_time("count_expired", 0, 0, 1, 1);
        expect_pulses("pulse_once", 1);
        step(1);
        expect_time("expired_drop", 0, 0, 1, 0);
        step(8);
        expect_time("count_at_zero", 0, 0, 1, 0);

        // Partial-period discard across a HOLD excursion.
        ctl(0, 1, 0, 1);
        step(20);
        expect_time("preload_0010", 0, 10, 0, 0);
        ctl(0, 1, 1, 0);
        step(3);
        expect_time("partial_3", 0, 10, 0, 0);
        ctl(0, 0, 0, 0);
        step(3);
        expect_time("partial_hold", 0, 10, 0, 0);
        ctl(0, 1, 1, 0);
        step(3);
        expect_time("partial_no_carry", 0, 10, 0, 0);
        step(1);
        expect_time("partial_full", 0, 9, 0, 0);

        // resetTimer coincident with the terminal count at 00:01.
        step(32);
        expect_time("pre_clear_0001", 0, 1, 0, 0);
        step(3);
        ctl(1, 1, 1, 0);
        step(1);
        expect_time("clear_wins", 0, 0, 1, 0);
        ctl(0, 1, 1, 0);
        step(5);
        expect_time("after_clear", 0, 0, 1, 0);
        expect_pulses("no_extra_pulse", 1);

        // Asynchronous reset mid-run.
        ctl(0, 0, 1, 1);
        step(6);
        expect_time("preload_0300", 3, 0, 0, 0);
        ctl(0, 1, 0, 1);
        step(1);
        #1 reset = 1'b1;
        expect_time("async_reset", 0, 0, 1, 0);
        step(1);
        ctl(0, 0, 0, 0);
        reset = 1'b0;
        step(3);
        expect_time("hold_after_async", 0, 0, 1, 0);
        ctl(0, 1, 0, 1);
        step(1);
        expect_time("restart_partial", 0, 0, 1, 0);
        step(1);
        expect_time("restart_full", 0, 1, 0, 0);

        step(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_tick_scheduler.md
# timer_tick_scheduler

Schedules the mm:ss time-keeping datapath of the VGA monitor timer. It consumes the per-cycle control levels produced by the timer control FSM (`enableSeg`, `enableMin`, `forward`, `resetTimer`) and owns the BCD minutes/seconds registers that the display path renders. It provides the 1 Hz countdown tick, the auto-repeat increment rate used while setting the time, and the end-of-countdown event.

## Interface
- `TICK_DIV`, 50_000_000: clk cycles per countdown tick (1 s at 50 MHz); must be ≥ 2.
- `SET_DIV`, 12_500_000: clk cycles per auto-repeat increment in setting mode (4 Hz); must be ≥ 2.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `enableSeg`  in  1  seconds field enabled (from control FSM).
- `enableMin`  in  1  minutes field enabled (from control FSM).
- `forward`  in  1  1 = setting (increment) mode, 0 = countdown.
- `resetTimer`  in  1  synchronous clear of time to 00:00.
- `secOnes`  out  4  BCD seconds units, 0–9.
- `secTens`  out  3  BCD seconds tens, 0–5.
- `minOnes`  out  4  BCD minutes units, 0–9.
- `minTens`  out  3  BCD minutes tens, 0–5.
- `zero`  out  1  level: time equals 00:00.
- `expired`  out  1  one-cycle pulse: countdown just reached 00:00.

## Operation
- Mode decode from control levels, priority order:
  - RESET: `resetTimer`=1.
  - COUNT: `enableSeg`=1, `enableMin`=1, `forward`=0.
  - SET_SEC: `forward`=1, `enableSeg`=1, `enableMin`=0.
  - SET_MIN: `forward`=1, `enableSeg`=0, `enableMin`=1.
  - HOLD: any other combination, including `forward`=1 with both enables set.
- RESET: time is forced to 00:00 every cycle while asserted; prescaler cleared; `expired` held at 0.
- COUNT: the prescaler counts 0..TICK_DIV-1. At terminal count, the time decrements by one second.
  - Seconds borrow: 00 → 59 and minutes decrement.
  - If time is already 00:00 at terminal count, time holds and no pulse is generated.
  - The decrement that produces 00:00 asserts `expired` for exactly one cycle.
- SET_SEC / SET_MIN: the prescaler counts 0..SET_DIV-1. At terminal count, only the selected field increments.
  - Wrap is 59 → 00 with no carry into the other field.
- HOLD: time and prescaler both frozen.
- Any mode change clears the prescaler. The first tick in a new mode therefore occurs a full period after entry; partial periods are never carried over.
- `zero` is combinational from the registered time.
- BCD invariant: no digit ever leaves its legal range, including after borrow or wrap.

## Timing
- Reset values: all digits 0, `zero`=1, `expired`=0, prescaler 0, stored mode HOLD.
- Entering COUNT at cycle 0 gives the first decrement on the rising edge ending cycle TICK_DIV-1. New digits are visible from cycle TICK_DIV; later decrements follow every TICK_DIV cycles.
- SET modes behave the same way with SET_DIV in place of TICK_DIV.
- `expired` is registered and coincides with the first cycle in which the digits show 00:00.
- `resetTimer` asserted in the same cycle as a terminal count: the clear wins, with no decrement and no pulse.
- Asynchronous `reset` mid-count: immediate clear. After deassertion, counting restarts with a full period.
- Control inputs are synchronous to `clk`; they are not re-synchronized internally.

## Structure
- Shared package `timer_pkg`:
  - Digit widths: 4 for ones, 3 for tens.
  - Mode encoding localparams: RESET, COUNT, SET_SEC, SET_MIN, HOLD.
  - Constants MAX_TENS=5 and MAX_ONES=9.
- Sub-module `bcd60_counter`, instantiated twice (seconds, minutes):
  - Inputs: `clk`, `reset`, `clear`, `inc`, `dec`.
  - Outputs: ones/tens digits, `isZero`, and `borrow` (asserted when `dec` is applied at 00).
  - Wraps 59↔00.
- The top level holds the mode decode, prescaler and `expired` register, and chains seconds `borrow` into minutes `dec`.

## Test plan
All scenarios use TICK_DIV=4 and SET_DIV=2.
- Reset sequence: assert `reset` mid-run → digits 00:00, `zero`=1, `expired`=0 immediately. Deassert → values held in HOLD.
- SET_MIN: hold SET_MIN for 122 cycles from 00:00 → minutes reach 61 mod 60 = 01 (wrap 59→00 observed once), seconds stay 00.
- SET_SEC: preload 00:58 via SET_SEC, then 2 more ticks → shows 00:00 with minutes unchanged and no `expired` pulse.
- Countdown borrow: from 01:00, enter COUNT → after 4 cycles 00:59; after 236 more cycles 00:00 with `expired` high for one cycle exactly when 00:00 appears. A further 8 cycles → still 00:00, no pulse.
- Partial-period discard: in COUNT at 00:10, switch to HOLD after 3 cycles, return to COUNT → next decrement occurs 4 cycles after return, not 1.
- Clear priority: `resetTimer` pulse coincident with the terminal count at 00:01 → 00:00, `expired` stays 0.
